// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key code values and the operand-entry state encoding.
package keypad_pkg;

   localparam logic [3:0] KEY_A    = 4'd10;
   localparam logic [3:0] KEY_B    = 4'd11;
   localparam logic [3:0] KEY_C    = 4'd12;
   localparam logic [3:0] KEY_D    = 4'd13;
   localparam logic [3:0] KEY_STAR = 4'd14;
   localparam logic [3:0] KEY_HASH = 4'd15;

   typedef enum logic [1:0] {
      ENTER_A = 2'd0,
      ENTER_B = 2'd1,
      HOLD    = 2'd2
   } entry_state_e;

endpackage

// File: rtl/keypad_key_event.sv
// Turns the debounced key_valid level into a one-cycle key_event strobe on its rising edge.
module keypad_key_event
   import keypad_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   output logic       key_event,
   output logic [3:0] event_code
);

   logic valid_prev_q;
   logic valid_prev_d;

   always_comb valid_prev_d = key_valid;

   always_ff @(posedge clk) begin
      if (rst) valid_prev_q <= 1'b0;
      else     valid_prev_q <= valid_prev_d;
   end

   // Clearing the history in reset lets a key held through reset release fire once.
   assign key_event  = key_valid & ~valid_prev_q;
   assign event_code = key_code;

endmodule

// File: rtl/keypad_operand_entry.sv
// Assembles BCD operands A and B from keypad events and offers the pair over valid/ready.
// Optional feature: define KEYPAD_ENTRY_BACKSPACE_EN to make key * delete the last digit.
//
// state   | meaning
// ENTER_A | typing operand A
// ENTER_B | typing operand B
// HOLD    | pair offered downstream, waiting for ready (only D is honoured)
module keypad_operand_entry
   import keypad_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [3:0]          key_code,
   input  logic                key_valid,
   output logic [4*DIGITS-1:0] entry_bcd,
   output logic [2:0]          entry_count,
   output logic                entry_is_b,
   output logic [4*DIGITS-1:0] operand_a,
   output logic [4*DIGITS-1:0] operand_b,
   output logic                operands_valid,
   input  logic                operands_ready
);

   localparam int W = 4*DIGITS;

   logic       key_event;
   logic [3:0] event_code;

   entry_state_e   state_q, state_d;
   logic [W-1:0]   entry_bcd_q, entry_bcd_d;
   logic [2:0]     entry_count_q, entry_count_d;
   logic [W-1:0]   operand_a_q, operand_a_d;
   logic [W-1:0]   operand_b_q, operand_b_d;

   keypad_key_event u_key_event (
      .clk        (clk),
      .rst        (rst),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .key_event  (key_event),
      .event_code (event_code)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ENTER_A;
         entry_bcd_q   <= '0;
         entry_count_q <= '0;
         operand_a_q   <= '0;
         operand_b_q   <= '0;
      end else begin
         state_q       <= state_d;
         entry_bcd_q   <= entry_bcd_d;
         entry_count_q <= entry_count_d;
         operand_a_q   <= operand_a_d;
         operand_b_q   <= operand_b_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      entry_bcd_d   = entry_bcd_q;
      entry_count_d = entry_count_q;
      operand_a_d   = operand_a_q;
      operand_b_d   = operand_b_q;

      if (state_q == HOLD) begin
         // Restart beats a same-cycle handshake: the pair is dropped.
         if (key_event && event_code == KEY_D) begin
            state_d     = ENTER_A;
            operand_a_d = '0;
            operand_b_d = '0;
         end else if (operands_ready) begin
            state_d = ENTER_A;
         end
      end else if (key_event) begin
         if (event_code < KEY_A) begin
            if (entry_count_q < 3'(DIGITS)) begin
               entry_bcd_d   = (entry_bcd_q << 4) | W'(event_code);
               entry_count_d = entry_count_q + 3'd1;
            end
         end else begin
            case (event_code)
               KEY_A: begin
                  if (state_q == ENTER_A) begin
                     operand_a_d   = entry_bcd_q;
                     entry_bcd_d   = '0;
                     entry_count_d = '0;
                     state_d       = ENTER_B;
                  end
               end
               KEY_B: begin
                  if (state_q == ENTER_B) begin
                     operand_b_d   = entry_bcd_q;
                     entry_bcd_d   = '0;
                     entry_count_d = '0;
                     state_d       = HOLD;
                  end
               end
               KEY_C: begin
                  entry_bcd_d   = '0;
                  entry_count_d = '0;
               end
               KEY_D: begin
                  entry_bcd_d   = '0;
                  entry_count_d = '0;
                  operand_a_d   = '0;
                  operand_b_d   = '0;
                  state_d       = ENTER_A;
               end
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
               KEY_STAR: begin
                  if (entry_count_q != 3'd0) begin
                     entry_bcd_d   = entry_bcd_q >> 4;
                     entry_count_d = entry_count_q - 3'd1;
                  end
               end
`endif
               default: ;
            endcase
         end
      end
   end

   assign entry_bcd      = entry_bcd_q;
   assign entry_count    = entry_count_q;
   assign entry_is_b     = (state_q == ENTER_B);
   assign operand_a      = operand_a_q;
   assign operand_b      = operand_b_q;
   assign operands_valid = (state_q == HOLD);

endmodule

// File: tb/tb_keypad_operand_entry.sv
// Bench for keypad_operand_entry: digit-queue model checked every cycle plus literal expectations.
module tb_keypad_operand_entry;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  key_code = 4'd0;
   logic        key_valid = 1'b0;
   logic        operands_ready = 1'b0;
   logic [11:0] entry_bcd;
   logic [2:0]  entry_count;
   logic        entry_is_b;
   logic [11:0] operand_a;
   logic [11:0] operand_b;
   logic        operands_valid;

   int pass_cnt = 0;
   int total_cnt = 0;
   bit checking = 1'b0;

   always #5 clk = ~clk;

   keypad_operand_entry #(.DIGITS(3)) dut (
      .clk            (clk),
      .rst            (rst),
      .key_code       (key_code),
      .key_valid      (key_valid),
      .entry_bcd      (entry_bcd),
      .entry_count    (entry_count),
      .entry_is_b     (entry_is_b),
      .operand_a      (operand_a),
      .operand_b      (operand_b),
      .operands_valid (operands_valid),
      .operands_ready (operands_ready)
   );

   // Model: phase 0 = typing A, 1 = typing B, 2 = pair waiting; entry kept as a digit list.
   int          m_phase = 0;
   int          m_digits[$];
   logic [11:0] m_a = '0;
   logic [11:0] m_b = '0;
   bit          m_prev = 1'b0;

   function automatic logic [11:0] digits_to_bcd(input int q[$]);
      logic [11:0] v;
      v = '0;
      foreach (q[i]) v = {v[7:0], q[i][3:0]};
      return v;
   endfunction

   always @(posedge clk) begin
      bit ev;
      ev = key_valid && !m_prev;
      if (rst) begin
         m_phase = 0;
         m_digits.delete();
         m_a = '0;
         m_b = '0;
      end else if (m_phase == 2) begin
         if (ev && key_code == 4'd13) begin
            m_phase = 0;
            m_a = '0;
            m_b = '0;
         end else if (operands_ready) begin
            m_phase = 0;
         end
      end else if (ev) begin
         if (key_code <= 4'd9) begin
            if (m_digits.size() < 3) m_digits.push_back(int'(key_code));
         end else if (key_code == 4'd10 && m_phase == 0) begin
            m_a = digits_to_bcd(m_digits);
            m_digits.delete();
            m_phase = 1;
         end else if (key_code == 4'd11 && m_phase == 1) begin
            m_b = digits_to_bcd(m_digits);
            m_digits.delete();
            m_phase = 2;
         end else if (key_code == 4'd12) begin
            m_digits.delete();
         end else if (key_code == 4'd13) begin
            m_digits.delete();
            m_a = '0;
            m_b = '0;
            m_phase = 0;
         end
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
         else if (key_code == 4'd14 && m_digits.size() > 0) begin
            void'(m_digits.pop_back());
         end
`endif
      end
      m_prev = rst ? 1'b0 : key_valid;
   end

   always @(negedge clk) begin
      if (checking) begin
         logic [11:0] e_bcd;
         e_bcd = digits_to_bcd(m_digits);
         total_cnt++;
         if (entry_bcd === e_bcd && entry_count === 3'(m_digits.size()) &&
             entry_is_b === (m_phase == 1) && operand_a === m_a && operand_b === m_b &&
             operands_valid === (m_phase == 2)) begin
            pass_cnt++;
         end else begin
            $display("FAIL model t=%0t: got bcd=%h cnt=%0d b=%0b a=%h b=%h v=%0b want bcd=%h cnt=%0d b=%0b a=%h b=%h v=%0b",
                     $time, entry_bcd, entry_count, entry_is_b, operand_a, operand_b, operands_valid,
                     e_bcd, m_digits.size(), (m_phase == 1), m_a, m_b, (m_phase == 2));
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic press(input logic [3:0] c, input int hold = 5, input int rel = 3);
      key_code  = c;
      key_valid = 1'b1;
      repeat (hold) cyc();
      key_valid = 1'b0;
      repeat (rel) cyc();
   endtask

   initial begin
      rst = 1'b1;
      cyc();
      checking = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_entry", 32'(entry_bcd), 32'h0);
      chk("reset_valid", 32'(operands_valid), 32'h0);
      chk("reset_is_b", 32'(entry_is_b), 32'h0);

      press(4'd1); press(4'd2); press(4'd3); press(4'd10);
      @(negedge clk);
      chk("after_A_is_b", 32'(entry_is_b), 32'h1);
      press(4'd4); press(4'd5); press(4'd11);
      @(negedge clk);
      chk("operand_a", 32'(operand_a), 32'h123);
      chk("operand_b", 32'(operand_b), 32'h045);
      chk("valid_hold", 32'(operands_valid), 32'h1);
      cyc();
      operands_ready = 1'b1;
      cyc();
      operands_ready = 1'b0;
      @(negedge clk);
      chk("valid_after_ready", 32'(operands_valid), 32'h0);
      chk("a_retained", 32'(operand_a), 32'h123);
      chk("is_b_after_ready", 32'(entry_is_b), 32'h0);

      operands_ready = 1'b1;
      press(4'd7, 50, 3);
      operands_ready = 1'b0;
      @(negedge clk);
      chk("held_key_bcd", 32'(entry_bcd), 32'h007);
      chk("held_key_cnt", 32'(entry_count), 32'h1);
      press(4'd12);

      press(4'd9); press(4'd8); press(4'd7); press(4'd6);
      @(negedge clk);
      chk("overflow_bcd", 32'(entry_bcd), 32'h987);
      chk("overflow_cnt", 32'(entry_count), 32'h3);
      press(4'd12);
      @(negedge clk);
      chk("clear_bcd", 32'(entry_bcd), 32'h0);
      chk("clear_cnt", 32'(entry_count), 32'h0);

      press(4'd10); press(4'd2); press(4'd11);
      press(4'd5); press(4'd10); press(4'd14); press(4'd15);
      @(negedge clk);
      chk("hold_valid", 32'(operands_valid), 32'h1);
      chk("hold_zero_a", 32'(operand_a), 32'h000);
      chk("hold_b", 32'(operand_b), 32'h002);
      chk("hold_entry", 32'(entry_bcd), 32'h0);
      press(4'd13);
      @(negedge clk);
      chk("d_valid", 32'(operands_valid), 32'h0);
      chk("d_operand_b", 32'(operand_b), 32'h0);

      press(4'd1); press(4'd2); press(4'd14); press(4'd3);
      @(negedge clk);
`ifdef KEYPAD_ENTRY_BACKSPACE_EN
      chk("star_bcd", 32'(entry_bcd), 32'h013);
`else
      chk("star_bcd", 32'(entry_bcd), 32'h123);
`endif
      press(4'd12); press(4'd14);
      @(negedge clk);
      chk("star_empty_cnt", 32'(entry_count), 32'h0);

      press(4'd6); press(4'd10); press(4'd11);
      operands_ready = 1'b1;
      press(4'd13);
      operands_ready = 1'b0;
      @(negedge clk);
      chk("d_vs_ready_a", 32'(operand_a), 32'h0);

      press(4'd4); press(4'd10); press(4'd6);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      @(negedge clk);
      chk("rst_outputs", 32'({entry_bcd, entry_count, entry_is_b, operand_a, operands_valid}), 32'h0);
      chk("rst_operand_b", 32'(operand_b), 32'h0);

      rst = 1'b1;
      key_code = 4'd8;
      key_valid = 1'b1;
      cyc(); cyc();
      rst = 1'b0;
      repeat (3) cyc();
      key_valid = 1'b0;
      repeat (3) cyc();
      @(negedge clk);
      chk("held_through_rst_bcd", 32'(entry_bcd), 32'h008);
      chk("held_through_rst_cnt", 32'(entry_count), 32'h1);

      checking = 1'b0;
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
